// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - request/response bus between the MEM stage and data_mem_ctrl
interface data_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - word RAM with byte/half/word access, wait states and error reporting
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 0
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus
);
    localparam int             IDX_W     = ADDR_WIDTH - 2;
    localparam int             MEM_W     = $clog2(DEPTH);
    localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(DEPTH);
    localparam logic [3:0]     WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic                  lat_write;
    logic                  lat_unsigned;
    logic [1:0]            lat_size;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_wdata;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  execute;
    logic                  rsp_fire;
    logic [1:0]            lane;
    logic [IDX_W-1:0]      word_idx;
    logic [MEM_W-1:0]      mem_idx;
    logic                  range_err;
    logic                  align_err;
    logic                  access_err;
    logic [3:0]            be;
    logic [31:0]           wd_lanes;
    logic [31:0]           rd_word;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [31:0]           load_val;

    assign accept   = bus.req_valid && bus.req_ready;
    assign execute  = (state == BUSY) && (cnt == 4'd0);
    assign rsp_fire = (state == RESP) && bus.rsp_ready;

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured only on the accept edge; later bus changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 4'd0;
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= 2'b00;
            lat_addr     <= '0;
            lat_wdata    <= 32'd0;
        end else if (accept) begin
            cnt          <= WAIT_INIT;
            lat_write    <= bus.req_write;
            lat_unsigned <= bus.req_unsigned;
            lat_size     <= bus.req_size;
            lat_addr     <= bus.req_addr;
            lat_wdata    <= bus.req_wdata;
        end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign lane      = lat_addr[1:0];
    assign word_idx  = lat_addr[ADDR_WIDTH-1:2];
    assign mem_idx   = lat_addr[MEM_W+1:2];
    assign range_err = ({1'b0, word_idx} >= DEPTH_LIM);
    assign align_err = (lat_size == 2'b11)
                    || (lat_size == 2'b01 && lane[0])
                    || (lat_size == 2'b10 && lane != 2'b00);
    assign access_err = range_err || align_err;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be       = 4'b0000;
        wd_lanes = lat_wdata;
        case (lat_size)
            2'b00: begin
                be       = 4'b0001 << lane;
                wd_lanes = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{lat_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (execute && lat_write && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[mem_idx][i*8 +: 8] <= wd_lanes[i*8 +: 8];
                end
            end
        end
    end

    assign rd_word  = mem[mem_idx];
    assign sel_byte = rd_word[{lane, 3'b000} +: 8];
    assign sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        case (lat_size)
            2'b00:   load_val = {{24{!lat_unsigned && sel_byte[7]}}, sel_byte};
            2'b01:   load_val = {{16{!lat_unsigned && sel_half[15]}}, sel_half};
            default: load_val = rd_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (execute) begin
            err_q   <= access_err;
            rdata_q <= (access_err || lat_write) ? 32'd0 : load_val;
        end else if (rsp_fire) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed scoreboard bench for data_mem_ctrl at zero and three wait states
`timescale 1ns/1ps
module tb_data_mem_ctrl;
    localparam int AW = 10;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic use3 = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   leak = 0;
    int   last_acc = 0;
    int   prev_acc = 0;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_ctrl_if #(.ADDR_WIDTH(AW)) bi0 ();
    data_mem_ctrl_if #(.ADDR_WIDTH(AW)) bi3 ();

    data_mem_ctrl #(.ADDR_WIDTH(AW), .DEPTH(128), .WAIT_STATES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bi0.slave)
    );

    data_mem_ctrl #(.ADDR_WIDTH(AW), .DEPTH(128), .WAIT_STATES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bi3.slave)
    );

    wire        m_req_ready = use3 ? bi3.req_ready : bi0.req_ready;
    wire        m_rsp_valid = use3 ? bi3.rsp_valid : bi0.rsp_valid;
    wire [31:0] m_rsp_rdata = use3 ? bi3.rsp_rdata : bi0.rsp_rdata;
    wire        m_rsp_err   = use3 ? bi3.rsp_err   : bi0.rsp_err;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] sz, input logic u,
                         input logic [AW-1:0] a, input logic [31:0] d);
        bi0.req_write = w;  bi3.req_write = w;
        bi0.req_size = sz;  bi3.req_size = sz;
        bi0.req_unsigned = u; bi3.req_unsigned = u;
        bi0.req_addr = a;   bi3.req_addr = a;
        bi0.req_wdata = d;  bi3.req_wdata = d;
        bi0.req_valid = v && !use3;
        bi3.req_valid = v && use3;
    endtask

    task automatic set_rsp_ready(input logic r);
        bi0.rsp_ready = r && !use3;
        bi3.rsp_ready = r && use3;
    endtask

    task automatic transact(input string tag, input logic w, input logic [1:0] sz, input logic u,
                            input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [31:0] exp_d, input logic exp_e, input int hold);
        exp_t        ent;
        int          n;
        int          unstable;
        logic [31:0] first_d;
        @(negedge clk);
        drive(1'b1, w, sz, u, a, d);
        n = 0;
        while (m_req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 32'(m_req_ready), 32'd1);
        @(posedge clk);
        #1;
        last_acc = cyc;
        ent.d = exp_d;
        ent.e = exp_e;
        sb.push_back(ent);
        // A conflicting store stays on the bus while busy; it must never be taken.
        drive(1'b1, 1'b1, 2'b10, 1'b0, 10'h010, 32'h0BAD0BAD);
        n = 0;
        while (m_rsp_valid !== 1'b1 && n < 50) begin
            if (m_req_ready !== 1'b0) leak++;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), use3 ? 32'd4 : 32'd1);
        first_d  = m_rsp_rdata;
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (m_rsp_valid !== 1'b1 || m_rsp_rdata !== first_d || m_req_ready !== 1'b0) unstable++;
        end
        if (hold > 0) chk({tag, "_stable"}, 32'(unstable), 32'd0);
        @(negedge clk);
        set_rsp_ready(1'b1);
        if (sb.size() == 0) begin
            chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
        end else begin
            ent = sb.pop_front();
            chk({tag, "_rdata"}, m_rsp_rdata, ent.d);
            chk({tag, "_err"}, 32'(m_rsp_err), 32'(ent.e));
        end
        @(posedge clk);
        #1;
        set_rsp_ready(1'b0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 10'h000, 32'd0);
        chk({tag, "_done"}, 32'(m_rsp_valid), 32'd0);
    endtask

    initial begin
        use3 = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 10'h000, 32'd0);
        set_rsp_ready(1'b0);
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(bi0.rsp_valid), 32'd0);
        chk("rst_rdata", bi0.rsp_rdata, 32'd0);
        chk("rst_err", 32'(bi0.rsp_err), 32'd0);
        chk("rst_rsp_valid3", 32'(bi3.rsp_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_req_ready0", 32'(bi0.req_ready), 32'd1);
        chk("rst_req_ready3", 32'(bi3.req_ready), 32'd1);

        // zero wait states: basic, sub-word and extension cases
        transact("st_w",    1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        transact("ld_w",    1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        transact("st_b",    1'b1, 2'b00, 1'b0, 10'h013, 32'hFFFFFF80, 32'h0, 1'b0, 0);
        transact("ld_bs",   1'b0, 2'b00, 1'b0, 10'h013, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        transact("ld_bu",   1'b0, 2'b00, 1'b1, 10'h013, 32'h0, 32'h00000080, 1'b0, 0);
        transact("ld_w2",   1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'h80ADBEEF, 1'b0, 0);
        transact("ld_bs1",  1'b0, 2'b00, 1'b0, 10'h011, 32'h0, 32'hFFFFFFBE, 1'b0, 0);
        transact("ld_bu2",  1'b0, 2'b00, 1'b1, 10'h012, 32'h0, 32'h000000AD, 1'b0, 0);
        transact("st_w14",  1'b1, 2'b10, 1'b0, 10'h014, 32'h00000000, 32'h0, 1'b0, 0);
        transact("st_h16",  1'b1, 2'b01, 1'b0, 10'h016, 32'hFFFFF00D, 32'h0, 1'b0, 0);
        transact("ld_w14",  1'b0, 2'b10, 1'b0, 10'h014, 32'h0, 32'hF00D0000, 1'b0, 0);
        transact("ld_hs16", 1'b0, 2'b01, 1'b0, 10'h016, 32'h0, 32'hFFFFF00D, 1'b0, 0);
        transact("ld_hu16", 1'b0, 2'b01, 1'b1, 10'h016, 32'h0, 32'h0000F00D, 1'b0, 0);
        transact("ld_hu14", 1'b0, 2'b01, 1'b1, 10'h014, 32'h0, 32'h00000000, 1'b0, 0);

        // illegal accesses: responded with err, memory untouched
        transact("e_h11",   1'b0, 2'b01, 1'b0, 10'h011, 32'h0, 32'h0, 1'b1, 0);
        transact("e_w12",   1'b1, 2'b10, 1'b0, 10'h012, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        transact("e_sz3",   1'b0, 2'b11, 1'b0, 10'h010, 32'h0, 32'h0, 1'b1, 0);
        transact("e_sz3st", 1'b1, 2'b11, 1'b0, 10'h010, 32'h11111111, 32'h0, 1'b1, 0);
        transact("e_rng",   1'b0, 2'b10, 1'b0, 10'h200, 32'h0, 32'h0, 1'b1, 0);
        transact("e_rngst", 1'b1, 2'b10, 1'b0, 10'h210, 32'h22222222, 32'h0, 1'b1, 0);
        transact("ld_w3",   1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'h80ADBEEF, 1'b0, 0);

        // three wait states, response back-pressure
        use3 = 1'b1;
        transact("w3_st",   1'b1, 2'b10, 1'b0, 10'h040, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        transact("w3_ld",   1'b0, 2'b10, 1'b0, 10'h040, 32'h0, 32'hCAFEF00D, 1'b0, 5);
        transact("w3_z20",  1'b1, 2'b10, 1'b0, 10'h020, 32'h00000000, 32'h0, 1'b0, 0);

        // reset while a response is pending
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 10'h040, 32'h0);
        chk("rr_ready", 32'(m_req_ready), 32'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 10'h000, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("rr_valid_pre", 32'(m_rsp_valid), 32'd1);
        chk("rr_rdata_pre", m_rsp_rdata, 32'hCAFEF00D);
        rst = 1'b1;
        #1;
        chk("rr_valid", 32'(m_rsp_valid), 32'd0);
        chk("rr_rdata", m_rsp_rdata, 32'd0);
        chk("rr_err", 32'(m_rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // reset during BUSY of a store drops the store
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b10, 1'b0, 10'h020, 32'h12345678);
        chk("rb_ready", 32'(m_req_ready), 32'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 10'h000, 32'd0);
        @(posedge clk);
        #1;
        chk("rb_busy", 32'(m_req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rb_valid", 32'(m_rsp_valid), 32'd0);
        chk("rb_rdata", m_rsp_rdata, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rb_req_ready", 32'(m_req_ready), 32'd1);
        transact("rb_ld",   1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 32'h00000000, 1'b0, 0);

        // back-to-back issue interval
        transact("b3_a",    1'b0, 2'b10, 1'b0, 10'h040, 32'h0, 32'hCAFEF00D, 1'b0, 0);
        prev_acc = last_acc;
        transact("b3_b",    1'b0, 2'b10, 1'b0, 10'h040, 32'h0, 32'hCAFEF00D, 1'b0, 0);
        chk("b3_int1", 32'(last_acc - prev_acc), 32'd6);
        prev_acc = last_acc;
        transact("b3_c",    1'b0, 2'b00, 1'b1, 10'h041, 32'h0, 32'h000000F0, 1'b0, 0);
        chk("b3_int2", 32'(last_acc - prev_acc), 32'd6);

        use3 = 1'b0;
        transact("b0_a",    1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'h80ADBEEF, 1'b0, 0);
        prev_acc = last_acc;
        transact("b0_b",    1'b0, 2'b01, 1'b0, 10'h012, 32'h0, 32'hFFFF80AD, 1'b0, 0);
        chk("b0_int1", 32'(last_acc - prev_acc), 32'd3);

        chk("no_accept_busy_resp", 32'(leak), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised, clocked successor to the processor's single-port data memory. Word-organised RAM behind a valid/ready request channel and a valid/ready response channel. Supports byte, half-word and word loads and stores, with sign or zero extension on loads and byte-lane write enables on stores. Adds configurable wait states and reports misaligned or out-of-range accesses as errors. Sits between the MEM pipeline stage and the storage array.

Parameters:
- ADDR_WIDTH, 9, byte-address width.
- DEPTH, 128, number of 32-bit words (a power of two, with DEPTH*4 <= 2**ADDR_WIDTH).
- WAIT_STATES, 0, extra cycles inserted before the access completes (0..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  a request is presented.
- req_ready  output  1  the block can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data, right-aligned (low byte/half used).
- rsp_valid  output  1  a response is available.
- rsp_ready  input  1  the consumer takes the response.
- rsp_rdata  output  32  load result, already extended; 0 for stores and errors.
- rsp_err  output  1  the access was illegal, misaligned or out of range.

Behaviour:
- Reset values: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, state = IDLE, wait counter = 0, req_ready = 1 once reset deasserts. Memory contents are not reset (undefined until written).
- Reset is asynchronous: asserting it mid-operation aborts immediately and returns to IDLE. A store not yet committed is dropped. Any pending response is discarded.
- State machine: IDLE -> BUSY -> RESP -> IDLE.
  - IDLE: req_ready = 1. On req_valid & req_ready, the block latches all req_* fields and loads the counter with WAIT_STATES, then moves to BUSY.
  - BUSY: req_ready = 0. Counter decrements each cycle. At the clock edge where counter == 0, the access executes (store commits or load captures) and the state moves to RESP.
  - RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable. On rsp_valid & rsp_ready, the state moves to IDLE. req_ready is 0 in RESP, so only one request is outstanding at a time.
- Latency: rsp_valid rises WAIT_STATES+1 clock edges after the accept edge. Minimum issue interval is WAIT_STATES+3 cycles when rsp_ready is held high.
- Addressing: word index = addr[ADDR_WIDTH-1:2]; lane = addr[1:0]. Byte lanes are little-endian: lane 0 = bits 7:0.
- Error conditions, checked on the latched request:
  - size = 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - word index >= DEPTH.
  
  On error: no memory write, rsp_err = 1, rsp_rdata = 0. The response is still delivered through the normal handshake.
- Store, byte: write wdata[7:0] into lane addr[1:0] only. Store, half: write wdata[15:0] into lanes {addr[1],0} and {addr[1],1}. Store, word: write all four lanes. Unselected lanes are unchanged.
- Load: extract the selected byte or half, then extend to 32 bits according to req_unsigned. A word load returns the word unchanged. rsp_err = 0.
- Store response: rsp_rdata = 0, rsp_err = 0 when the store is legal.
- req_* inputs are ignored outside the IDLE accept cycle. A change to req_* after acceptance has no effect.
- Read-after-write: a load accepted after a store's response returns the stored data; there is no stale read.

Test Plan:
- Reset, then a word store of 0xDEADBEEF to 0x010 followed by a word load from 0x010, with WAIT_STATES = 0 -> rsp_valid one edge after accept; load returns 0xDEADBEEF with rsp_err = 0.
- Byte store 0x80 to 0x013, then signed byte load from 0x013 -> 0xFFFFFF80. Unsigned byte load -> 0x00000080. Word load from 0x010 -> 0x80ADBEEF.
- Half load from 0x011, word store to 0x012, size = 11, and word load from 0x200 with ADDR_WIDTH = 10 -> each gives rsp_err = 1 and rsp_rdata = 0. A following word load from 0x010 shows memory unchanged.
- WAIT_STATES = 3: accept a load -> rsp_valid rises exactly 4 edges after the accept edge. Hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0 throughout.
- Assert rst during BUSY of a word store of 0x12345678 to 0x020 (word previously 0x0) -> outputs return to reset values immediately. A later load from 0x020 returns 0x00000000.
- Back-to-back requests with rsp_ready tied to 1 -> accepts occur every WAIT_STATES+3 cycles. No request is accepted while in BUSY or RESP.
